// File: rtl/spi_slave_ram_burst.sv
// spi_slave_ram_burst: clk-sampled SPI slave driving an internal RAM with burst access and a saturating frame-error count
module spi_slave_ram_burst #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_EN   = 1,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic                 busy,
  output logic [ERR_WIDTH-1:0] err_cnt
);
  localparam int SW = ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);
  typedef enum logic [2:0] {IDLE, OPC, WADDR, RADDR, WDATA, RDATA, DONE} state_t;
  state_t state;
  logic op_msb;
  logic [CW-1:0] cnt;
  logic [SW-1:0] sh, sh_nx;
  logic [DATA_WIDTH-1:0] rd_word, out_word;
  logic [DATA_WIDTH-1:0] mem [0:2**ADDR_WIDTH-1];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic addr_last, data_last, word_end, we, re, abort;
  assign sh_nx     = {sh[SW-2:0], MOSI};
  assign addr_last = cnt == CW'(ADDR_WIDTH - 1);
  assign data_last = cnt == CW'(DATA_WIDTH - 1);
  assign word_end  = cnt == CW'(DATA_WIDTH);
  assign out_word  = cnt == CW'(1) ? rd_word : sh[DATA_WIDTH-1:0];
  assign we        = !rst && !SS_n && state == WDATA && data_last;
  assign re        = !rst && !SS_n && state == RDATA && (cnt == '0 || (BURST_EN != 0 && word_end));
  assign abort     = (state == WADDR || state == WDATA) && cnt != '0;
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= sh_nx[DATA_WIDTH-1:0];
    if (re) rd_word <= mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      MISO    <= 1'b0;
      busy    <= 1'b0;
      op_msb  <= 1'b0;
      cnt     <= '0;
      sh      <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_cnt <= '0;
    end else if (SS_n) begin
      state <= IDLE;
      MISO  <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
      sh    <= '0;
      if (abort && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
    end else begin
      MISO <= 1'b0;
      busy <= 1'b1;
      case (state)
        IDLE: begin
          state <= OPC;
          cnt   <= '0;
        end
        OPC: begin
          op_msb <= MOSI;
          cnt    <= cnt == '0 ? CW'(1) : '0;
          if (cnt != '0) state <= op_msb ? (MOSI ? RDATA : RADDR) : (MOSI ? WDATA : WADDR);
        end
        WADDR, RADDR: begin
          sh  <= sh_nx;
          cnt <= addr_last ? '0 : cnt + 1'b1;
          if (addr_last && state == WADDR) wr_ptr <= sh_nx[ADDR_WIDTH-1:0];
          if (addr_last && state == RADDR) rd_ptr <= sh_nx[ADDR_WIDTH-1:0];
          if (addr_last) state <= DONE;
        end
        WDATA: begin
          sh  <= sh_nx;
          cnt <= data_last ? '0 : cnt + 1'b1;
          if (data_last) wr_ptr <= wr_ptr + 1'b1;
          if (data_last && BURST_EN == 0) state <= DONE;
        end
        RDATA: begin
          if (re) rd_ptr <= rd_ptr + 1'b1;
          if (cnt != '0) begin
            MISO                <= out_word[DATA_WIDTH-1];
            sh[DATA_WIDTH-1:0]  <= out_word << 1;
          end
          cnt <= word_end ? CW'(BURST_EN != 0) : cnt + 1'b1;
          if (word_end && BURST_EN == 0) state <= DONE;
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_slave_ram_burst.sv
// tb_spi_slave_ram_burst: directed frames against a default instance and a 4-bit-address/16-bit-data single-word instance
module tb_spi_slave_ram_burst;
  logic clk = 1'b0, rst = 1'b1;
  logic ss_a = 1'b1, mosi_a = 1'b0, ss_b = 1'b1, mosi_b = 1'b0;
  logic miso_a, busy_a, miso_b, busy_b;
  logic [7:0] err_a, err_b;
  logic [63:0] rx;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  spi_slave_ram_burst dut_a (
    .clk(clk), .rst(rst), .SS_n(ss_a), .MOSI(mosi_a), .MISO(miso_a), .busy(busy_a), .err_cnt(err_a)
  );
  spi_slave_ram_burst #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BURST_EN(0), .ERR_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .SS_n(ss_b), .MOSI(mosi_b), .MISO(miso_b), .busy(busy_b), .err_cnt(err_b)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input bit b, input logic [63:0] tx, input int n, output logic [63:0] r);
    r = '0;
    @(negedge clk);
    if (b) ss_b = 1'b0; else ss_a = 1'b0;
    for (int j = 0; j <= n; j++) begin
      @(negedge clk);
      r = {r[62:0], b ? miso_b : miso_a};
      if (j == n) begin
        if (b) ss_b = 1'b1; else ss_a = 1'b1;
      end else if (b) mosi_b = tx[n-1-j];
      else mosi_a = tx[n-1-j];
    end
    @(negedge clk);
    check("frame_end", {b ? busy_b : busy_a, b ? miso_b : miso_a}, 64'h0);
  endtask
  task automatic cmd(input bit b, input logic [1:0] op, input logic [31:0] payload, input int n);
    xfer(b, (64'(op) << n) | 64'(payload), n + 2, rx);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_a", {miso_a, busy_a, err_a}, 64'h0);
    check("rst_b", {miso_b, busy_b, err_b}, 64'h0);
    rst = 1'b0;
    cmd(0, 2'b00, 32'h3C, 8);
    cmd(0, 2'b01, 32'hA5, 8);
    cmd(0, 2'b10, 32'h3C, 8);
    cmd(0, 2'b11, 32'h0, 9);
    check("rd_default", rx[8:0], 64'h0A5);
    check("err_default", err_a, 64'h0);
    cmd(0, 2'b00, 32'hFE, 8);
    cmd(0, 2'b01, 32'h112233, 24);
    cmd(0, 2'b10, 32'hFE, 8);
    cmd(0, 2'b11, 32'h0, 25);
    check("burst_rd", rx[24:0], 64'h0112233);
    cmd(0, 2'b01, 32'h44, 8);
    cmd(0, 2'b10, 32'h01, 8);
    cmd(0, 2'b11, 32'h0, 9);
    check("wr_ptr_wrap", rx[7:0], 64'h44);
    cmd(0, 2'b10, 32'h00, 8);
    cmd(0, 2'b11, 32'h0, 9);
    check("wrap_word", rx[7:0], 64'h33);
    cmd(0, 2'b00, 32'h11, 8);
    cmd(0, 2'b01, 32'h5A, 8);
    cmd(0, 2'b00, 32'h11, 8);
    cmd(0, 2'b01, 32'h1F, 5);
    check("abort_err", err_a, 64'h1);
    cmd(0, 2'b10, 32'h11, 8);
    cmd(0, 2'b11, 32'h0, 9);
    check("abort_ram", rx[7:0], 64'h5A);
    cmd(0, 2'b01, 32'h77, 8);
    cmd(0, 2'b10, 32'h11, 8);
    cmd(0, 2'b11, 32'h0, 9);
    check("abort_ptr", rx[7:0], 64'h77);
    xfer(0, 64'h0, 1, rx);
    cmd(0, 2'b01, 32'h0, 0);
    cmd(0, 2'b11, 32'h0, 5);
    cmd(0, 2'b10, 32'h3, 4);
    cmd(0, 2'b00, 32'h11F, 12);
    check("no_err_ends", err_a, 64'h1);
    cmd(0, 2'b00, 32'h3, 4);
    check("addr_abort", err_a, 64'h2);
    repeat (253) cmd(0, 2'b01, 32'h1F, 5);
    check("err_255", err_a, 64'hFF);
    repeat (45) cmd(0, 2'b01, 32'h1F, 5);
    check("err_sat", err_a, 64'hFF);
    @(negedge clk);
    ss_a = 1'b0;
    repeat (6) @(negedge clk);
    check("busy_mid", busy_a, 64'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid", {miso_a, busy_a, err_a}, 64'h0);
    rst = 1'b0;
    ss_a = 1'b1;
    cmd(0, 2'b11, 32'h0, 9);
    check("rd_ptr_reset", rx[7:0], 64'h33);
    cmd(0, 2'b01, 32'h66, 8);
    cmd(0, 2'b10, 32'h00, 8);
    cmd(0, 2'b11, 32'h0, 9);
    check("wr_ptr_reset", rx[7:0], 64'h66);
    cmd(0, 2'b10, 32'h3C, 8);
    cmd(0, 2'b11, 32'h0, 9);
    check("ram_kept", rx[7:0], 64'hA5);
    cmd(1, 2'b00, 32'h0, 4);
    cmd(1, 2'b01, 32'h5555, 16);
    cmd(1, 2'b00, 32'hF, 4);
    cmd(1, 2'b01, 32'hBEEF1234, 32);
    cmd(1, 2'b10, 32'hF, 4);
    cmd(1, 2'b11, 32'h0, 19);
    check("b_rd_beef", rx[18:0], 64'h2FBBC);
    cmd(1, 2'b10, 32'h0, 4);
    cmd(1, 2'b11, 32'h0, 17);
    check("b_second_ignored", rx[15:0], 64'h5555);
    check("b_err", err_b, 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
